// File: rtl/sr_chk_pkg.sv
// Shared types and defaults for the master-slave SR flip-flop checker.
// Holds the checker FSM encoding and the settle-counter sizing.
package sr_chk_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_HIGH   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int SETTLE_DEF      = 3;

    // Wide enough for the largest supported settle time (15).
    localparam int SETTLE_W = 4;

    function automatic logic [SETTLE_W-1:0] settle_load(input int settle);
        return SETTLE_W'(settle - 1);
    endfunction

endpackage

// File: rtl/sr_msff_checker_sync_edge.sv
// N-stage synchronizer for a bundle of asynchronous bits, with rise/fall
// detection on bit 0 (the lead signal, here the observed flip-flop clock).
module sync_edge
    import sr_chk_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEF,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             rise,
    output logic             fall
);

    logic [WIDTH-1:0] pipe [STAGES];
    logic             lead_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
            lead_d <= 1'b0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
            lead_d <= pipe[STAGES-1][0];
        end
    end

    assign dout = pipe[STAGES-1];
    assign rise = dout[0] & ~lead_d;
    assign fall = ~dout[0] & lead_d;

endmodule

// File: rtl/sr_msff_checker.sv
// Oversampling monitor for a master-slave SR flip-flop: models the master latch
// while FF_C is high and checks Q / Qbar a fixed time after each FF_C fall.
module sr_msff_checker
    import sr_chk_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int SETTLE      = SETTLE_DEF,
    parameter int CNT_W       = 8
) (
    input  logic             C,
    input  logic             RST,
    input  logic             FF_C,
    input  logic             FF_S,
    input  logic             FF_R,
    input  logic             FF_Q,
    input  logic             FF_QBAR,
    input  logic             ERR_CLR,
    output logic             EXP_Q,
    output logic             EXP_VALID,
    output logic             MISMATCH,
    output logic             COMPL_ERR,
    output logic             ILLEGAL,
    output logic             CHECK_STB,
    output logic [CNT_W-1:0] ERR_CNT,
    output state_t           dbg_state
);

    logic [4:0] sync_bits;
    logic       fc, s, r, q, qbar;
    logic       fc_rise, fc_fall;

    // Bit 0 is the flip-flop clock; the data bits share the same delay so
    // they stay aligned with the edges detected on it.
    sync_edge #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (5)
    ) u_sync (
        .clk  (C),
        .rst  (RST),
        .din  ({FF_QBAR, FF_Q, FF_R, FF_S, FF_C}),
        .dout (sync_bits),
        .rise (fc_rise),
        .fall (fc_fall)
    );

    assign fc   = sync_bits[0];
    assign s    = sync_bits[1];
    assign r    = sync_bits[2];
    assign q    = sync_bits[3];
    assign qbar = sync_bits[4];

    state_t              state, state_next;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                capture;
    logic                m, m_valid;
    logic                exp_q_r, exp_valid_r;
    logic                mismatch_r, compl_err_r, illegal_r;
    logic [CNT_W-1:0]    err_cnt;

    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            ST_LOW: begin
                if (fc) state_next = ST_HIGH;
            end
            ST_HIGH: begin
                if (fc_fall) begin
                    state_next = ST_SETTLE;
                    capture    = 1'b1;
                end
            end
            ST_SETTLE: begin
                // A new high phase before the settle time expires means the
                // slave output was never stable long enough to judge.
                if (fc_rise)                 state_next = ST_HIGH;
                else if (settle_cnt == '0)   state_next = ST_CHECK;
            end
            ST_CHECK: begin
                state_next = fc ? ST_HIGH : ST_LOW;
            end
            default: state_next = ST_LOW;
        endcase
    end

    logic check_now, mis_hit, compl_hit, check_fail, illegal_hit;

    assign check_now   = (state == ST_CHECK);
    assign mis_hit     = check_now & exp_valid_r & (q != exp_q_r);
    assign compl_hit   = check_now & (q == qbar);
    assign check_fail  = mis_hit | compl_hit;
    assign illegal_hit = fc & s & r;

    always_ff @(posedge C) begin
        if (RST) begin
            state       <= ST_LOW;
            settle_cnt  <= '0;
            m           <= 1'b0;
            m_valid     <= 1'b0;
            exp_q_r     <= 1'b0;
            exp_valid_r <= 1'b0;
        end else begin
            state <= state_next;

            if (capture) begin
                settle_cnt <= settle_load(SETTLE);
            end else if (state == ST_SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - 1'b1;
            end

            // Master latch is transparent only while the observed clock is high.
            if (fc) begin
                if (s & ~r) begin
                    m       <= 1'b1;
                    m_valid <= 1'b1;
                end else if (r & ~s) begin
                    m       <= 1'b0;
                    m_valid <= 1'b1;
                end else if (s & r) begin
                    m_valid <= 1'b0;
                end
            end

            if (capture) begin
                exp_q_r     <= m;
                exp_valid_r <= m_valid;
            end
        end
    end

    always_ff @(posedge C) begin
        if (RST || ERR_CLR) begin
            mismatch_r  <= 1'b0;
            compl_err_r <= 1'b0;
            illegal_r   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            if (mis_hit)     mismatch_r  <= 1'b1;
            if (compl_hit)   compl_err_r <= 1'b1;
            if (illegal_hit) illegal_r   <= 1'b1;
            if (check_fail && err_cnt != {CNT_W{1'b1}}) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign EXP_Q     = exp_q_r;
    assign EXP_VALID = exp_valid_r;
    assign MISMATCH  = mismatch_r;
    assign COMPL_ERR = compl_err_r;
    assign ILLEGAL   = illegal_r;
    assign CHECK_STB = check_now;
    assign ERR_CNT   = err_cnt;
    assign dbg_state = state;

endmodule
